shifter_operand_unit: RTL and testbench

//  Multi-cycle ARM shifter-operand unit: data-processing operand-2 generator feeding the ALU.

---
 rtl/shifter_operand_unit.sv | 191 +++++++++++++++++++
 tb/tb_shifter_operand_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_operand_unit.sv
// Iterative ARM shifter-operand generator (imm rotate, LSL/LSR/ASR/ROR/RRX), STEP bits per clock.
// Optional macro SHIFTER_FASTPATH_EN: zero-count requests bypass the FSM combinationally while idle.
module shifter_operand_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [11:0]      imm12,
    input  logic [AMT_W-1:0] amount,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    // Handshake: a transfer happens on a rising edge where valid && ready; the producer holds
    // its payload stable while valid is high and ready is low; result/carry_out never change in DONE.
    localparam int IW = $clog2(WIDTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [2:0] {K_LSL, K_LSR, K_ASR, K_ROR, K_RRX} kind_t;

    state_t           state;
    kind_t            kind;
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    rem;
    logic             c_q, cin_q, zero_c_q;
    logic [WIDTH-1:0] res_q;
    logic             c_out_q, out_valid_q;

    // Request decode: starting data, shift count and the carry to report if the count is zero.
    kind_t            p_kind;
    logic [WIDTH-1:0] p_data;
    logic [CW-1:0]    p_eff;
    logic             p_c, p_zero_c, p_eff0;

    always_comb begin
        p_kind   = K_LSL;
        p_data   = operand;
        p_eff    = '0;
        p_c      = carry_in;
        p_zero_c = 1'b0;
        case (op)
            3'd0: begin
                p_kind = K_ROR;
                p_data = WIDTH'(imm12[7:0]);
                p_eff  = CW'({imm12[11:8], 1'b0} % WIDTH);
                if (imm12[11:8] != 4'd0) p_c = p_data[WIDTH-1];
            end
            3'd2, 3'd3: begin
                p_kind = (op == 3'd2) ? K_LSR : K_ASR;
                if (int'(amount) > WIDTH) begin
                    p_eff    = CW'(WIDTH);
                    p_zero_c = (op == 3'd2);
                end else begin
                    p_eff = CW'(amount);
                end
            end
            3'd4: begin
                p_kind = K_ROR;
                p_eff  = CW'(amount % WIDTH);
                if (amount != '0) p_c = operand[WIDTH-1];
            end
            3'd5: begin
                p_kind = K_RRX;
                p_eff  = CW'(1);
            end
            default: begin
                if (int'(amount) > WIDTH) begin
                    p_eff    = CW'(WIDTH);
                    p_zero_c = 1'b1;
                end else begin
                    p_eff = CW'(amount);
                end
            end
        endcase
        p_eff0 = (p_eff == '0);
    end

    // One iteration: move k = min(STEP, rem) bits and remember the last bit shifted out.
    logic [CW-1:0]    k, wk, km1;
    logic [WIDTH-1:0] step_data;
    logic             step_c;

    always_comb begin
        k         = (rem < CW'(STEP)) ? rem : CW'(STEP);
        wk        = CW'(WIDTH) - k;
        km1       = k - CW'(1);
        step_data = data;
        step_c    = c_q;
        case (kind)
            K_LSL: begin
                step_data = data << k;
                step_c    = data[wk[IW-1:0]];
            end
            K_LSR: begin
                step_data = data >> k;
                step_c    = data[km1[IW-1:0]];
            end
            K_ASR: begin
                step_data = $unsigned($signed(data) >>> k);
                step_c    = data[km1[IW-1:0]];
            end
            K_ROR: begin
                step_data = (data >> k) | (data << wk);
                step_c    = step_data[WIDTH-1];
            end
            default: begin
                step_data = {cin_q, data[WIDTH-1:1]};
                step_c    = data[0];
            end
        endcase
    end

    logic fast_hit;
`ifdef SHIFTER_FASTPATH_EN
    assign fast_hit = (state == S_IDLE) && p_eff0;
`else
    assign fast_hit = 1'b0;
`endif

    assign in_ready  = (state == S_IDLE) && (!fast_hit || out_ready);
    assign out_valid = fast_hit ? in_valid : out_valid_q;
    assign result    = fast_hit ? p_data : res_q;
    assign carry_out = fast_hit ? p_c : c_out_q;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            kind        <= K_LSL;
            data        <= '0;
            rem         <= '0;
            c_q         <= 1'b0;
            cin_q       <= 1'b0;
            zero_c_q    <= 1'b0;
            res_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready && !fast_hit) begin
                        if (p_eff0) begin
                            res_q       <= p_data;
                            c_out_q     <= p_c;
                            out_valid_q <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            kind     <= p_kind;
                            data     <= p_data;
                            rem      <= p_eff;
                            c_q      <= p_c;
                            cin_q    <= carry_in;
                            zero_c_q <= p_zero_c;
                            state    <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data <= step_data;
                    c_q  <= step_c;
                    rem  <= rem - k;
                    if (rem == k) begin
                        // Shifts past the width still run WIDTH bits; LSL/LSR then report C=0.
                        res_q       <= step_data;
                        c_out_q     <= zero_c_q ? 1'b0 : step_c;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shifter_operand_unit.sv
// Self-checking bench for shifter_operand_unit: vector table, directed stall/reset sequences,
// random requests against a reference model; expected results flow through a scoreboard queue.
module tb_shifter_operand_unit;
    localparam int W    = 32;
    localparam int STEP = 8;
`ifdef SHIFTER_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] operand = '0;
    logic [11:0]  imm12 = '0;
    logic [7:0]   amount = '0;
    logic         carry_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry_out;
    logic         busy;
    logic [1:0]   state_dbg;

    shifter_operand_unit #(.WIDTH(W), .STEP(STEP), .AMT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand(operand), .imm12(imm12), .amount(amount), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry_out(carry_out),
        .busy(busy), .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int num_checks = 0;
    int num_errors = 0;

    // Scoreboard: {carry, result}, expected latency, and cycle of acceptance
    logic [W:0] exp_q[$];
    int         lat_q[$];
    int         acc_q[$];
    bit         seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [2:0] m_op, input logic [W-1:0] x,
                                         input logic [11:0] imm, input logic [7:0] n8,
                                         input logic cin);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        logic           c;
        int             n, s;
        n = int'(n8);
        r = x;
        c = cin;
        case (m_op)
            3'd0: begin
                s  = 2 * int'(imm[11:8]);
                dd = {W'(imm[7:0]), W'(imm[7:0])} >> s;
                r  = dd[W-1:0];
                c  = (s == 0) ? cin : r[W-1];
            end
            3'd2: begin
                if (n == 0) begin r = x; c = cin; end
                else if (n < W) begin r = x >> n; c = x[n-1]; end
                else if (n == W) begin r = '0; c = x[W-1]; end
                else begin r = '0; c = 1'b0; end
            end
            3'd3: begin
                if (n == 0) begin r = x; c = cin; end
                else if (n < W) begin r = W'($signed(x) >>> n); c = x[n-1]; end
                else begin r = {W{x[W-1]}}; c = x[W-1]; end
            end
            3'd4: begin
                s = n % W;
                if (n == 0) begin r = x; c = cin; end
                else if (s == 0) begin r = x; c = x[W-1]; end
                else begin dd = {x, x} >> s; r = dd[W-1:0]; c = r[W-1]; end
            end
            3'd5: begin
                r = {cin, x[W-1:1]};
                c = x[0];
            end
            default: begin
                if (n == 0) begin r = x; c = cin; end
                else if (n < W) begin r = x << n; c = x[W-n]; end
                else if (n == W) begin r = '0; c = x[0]; end
                else begin r = '0; c = 1'b0; end
            end
        endcase
        return {c, r};
    endfunction

    function automatic int lat_model(input logic [2:0] m_op, input logic [11:0] imm,
                                     input logic [7:0] n8);
        int e;
        case (m_op)
            3'd0:    e = (2 * int'(imm[11:8])) % W;
            3'd4:    e = int'(n8) % W;
            3'd5:    e = 1;
            default: e = (int'(n8) > W) ? W : int'(n8);
        endcase
        if (e == 0) return FAST ? 0 : 1;
        return (e + STEP - 1) / STEP + 1;
    endfunction

    // Driver: present a request, wait (bounded) for acceptance, log expectations.
    task automatic send(input logic [2:0] t_op, input logic [W-1:0] t_x, input logic [11:0] t_imm,
                        input logic [7:0] t_n, input logic t_cin,
                        input logic [W:0] t_exp, input int t_lat);
        int guard;
        @(negedge clk);
        op = t_op; operand = t_x; imm12 = t_imm; amount = t_n; carry_in = t_cin;
        in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            num_checks++;
            num_errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
        end else begin
            exp_q.push_back(t_exp);
            lat_q.push_back(t_lat);
            acc_q.push_back(cyc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int stall);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
            if (guard >= stall) out_ready = 1'b1;
        end
        if (exp_q.size() != 0) begin
            num_checks++;
            num_errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete(); lat_q.delete(); acc_q.delete(); seen = 1'b0;
        end
        out_ready = 1'b1;
    endtask

    // Scoreboard monitor: compares every valid cycle against the queue head, pops on handshake.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (reset_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    num_checks++;
                    num_errors++;
                    $display("FAIL spurious_valid: out_valid=1 with no request outstanding");
                end else begin
                    if (!seen) begin
                        check("latency", 64'(cyc - acc_q[0]), 64'(lat_q[0]));
                        seen = 1'b1;
                    end
                    check("result", 64'(result), 64'(exp_q[0][W-1:0]));
                    check("carry_out", 64'(carry_out), 64'(exp_q[0][W]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(lat_q.pop_front());
                        void'(acc_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] x;
        logic [11:0]  imm;
        logic [7:0]   n;
        logic         cin;
        logic [W-1:0] res;
        logic         c;
        int           lat;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [2:0]   r_op;
        logic [W-1:0] r_x;
        logic [11:0]  r_imm;
        logic [7:0]   r_n;
        logic         r_cin;
        int           lat;
        int           guard;

        tbl[0]  = '{3'd0, 32'h0,        12'h4FF, 8'd0,  1'b0, 32'hFF000000, 1'b1, 2};
        tbl[1]  = '{3'd0, 32'h0,        12'h0AB, 8'd0,  1'b1, 32'h000000AB, 1'b1, 1};
        tbl[2]  = '{3'd1, 32'h80000001, 12'h0,   8'd1,  1'b0, 32'h00000002, 1'b1, 2};
        tbl[3]  = '{3'd1, 32'h80000001, 12'h0,   8'd32, 1'b0, 32'h00000000, 1'b1, 5};
        tbl[4]  = '{3'd1, 32'h80000001, 12'h0,   8'd33, 1'b1, 32'h00000000, 1'b0, 5};
        tbl[5]  = '{3'd1, 32'h80000001, 12'h0,   8'd0,  1'b1, 32'h80000001, 1'b1, 1};
        tbl[6]  = '{3'd2, 32'h80000000, 12'h0,   8'd32, 1'b0, 32'h00000000, 1'b1, 5};
        tbl[7]  = '{3'd3, 32'h80000000, 12'h0,   8'd40, 1'b0, 32'hFFFFFFFF, 1'b1, 5};
        tbl[8]  = '{3'd4, 32'h12345678, 12'h0,   8'd4,  1'b0, 32'h81234567, 1'b1, 2};
        tbl[9]  = '{3'd4, 32'h12345678, 12'h0,   8'd32, 1'b1, 32'h12345678, 1'b0, 1};
        tbl[10] = '{3'd5, 32'h00000001, 12'h0,   8'd9,  1'b1, 32'h80000000, 1'b1, 2};
        tbl[11] = '{3'd7, 32'h0000000F, 12'h0,   8'd4,  1'b1, 32'h000000F0, 1'b0, 2};
        tbl[12] = '{3'd2, 32'h0000F000, 12'h0,   8'd13, 1'b0, 32'h00000007, 1'b1, 3};
        tbl[13] = '{3'd3, 32'hF0000000, 12'h0,   8'd4,  1'b1, 32'hFF000000, 1'b0, 2};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_carry_out", 64'(carry_out), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_busy", 64'(busy), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            lat = (FAST && tbl[i].lat == 1) ? 0 : tbl[i].lat;
            send(tbl[i].op, tbl[i].x, tbl[i].imm, tbl[i].n, tbl[i].cin, {tbl[i].c, tbl[i].res}, lat);
            drain(1);
        end

        // Consumer stall in DONE, then two back-to-back requests
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(3'd4, 32'h12345678, 12'h0, 8'd4, 1'b0, {1'b1, 32'h81234567}, 2);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        check("stall_reached_done", 64'(out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd2, 32'h0000F000, 12'h0, 8'd13, 1'b0, {1'b1, 32'h00000007}, 3);
        send(3'd1, 32'h80000001, 12'h0, 8'd1, 1'b0, {1'b1, 32'h00000002}, 2);
        drain(1);

        // Random requests against the model, with random consumer back-pressure
        for (int i = 0; i < 40; i++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_x   = $urandom;
            r_imm = 12'($urandom_range(0, 4095));
            r_cin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       r_n = 8'd0;
                1:       r_n = 8'd32;
                2:       r_n = 8'($urandom_range(1, 31));
                3:       r_n = 8'($urandom_range(33, 255));
                default: r_n = 8'd64;
            endcase
            send(r_op, r_x, r_imm, r_n, r_cin, model(r_op, r_x, r_imm, r_n, r_cin),
                 lat_model(r_op, r_imm, r_n));
            out_ready = 1'($urandom_range(0, 1));
            drain($urandom_range(1, 4));
        end

        // Asynchronous reset in the middle of a long shift
        send(3'd3, 32'h80000000, 12'h0, 8'd40, 1'b0, {1'b1, 32'hFFFFFFFF}, 5);
        @(posedge clk); #2;
        check("pre_reset_busy", 64'(busy), 64'(1));
        reset_n = 1'b0;
        #1;
        check("midshift_reset_out_valid", 64'(out_valid), 64'(0));
        check("midshift_reset_result", 64'(result), 64'(0));
        check("midshift_reset_in_ready", 64'(in_ready), 64'(1));
        check("midshift_reset_busy", 64'(busy), 64'(0));
        exp_q.delete(); lat_q.delete(); acc_q.delete(); seen = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        send(3'd1, 32'h80000001, 12'h0, 8'd1, 1'b0, {1'b1, 32'h00000002}, 2);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end
endmodule
